// File: rtl/erasable_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// erasable_cycle_sequencer
//
// Purpose:
//   Steps through the 12 time pulses of a memory cycle time (MCT) and shares
//   the erasable array between the instruction sequencer (CPU) and the
//   counter-increment logic (CNT).
//
//   At the TP12 -> TP1 boundary, one requester is chosen (or the MCT stays
//   idle). Its address is latched for the whole MCT. The block then produces
//   one-hot X/Y driver enables and read/sense/rewrite/clear strobes at fixed
//   time pulses.
//
//   CNT normally wins. A pending CPU request is served once CNT has taken
//   CNT_LIMIT consecutive MCTs.
//
// Parameters:
//   CNT_LIMIT  max consecutive CNT grants while CPU_REQ pends (1..15)
//
// Ports:
//   CLOCK      system clock, rising edge
//   rst_       synchronous reset, active low
//   TICK       one-clock pulse, advance to the next time pulse
//   GOJAM      synchronous abort, active high (same effect as reset)
//   SBY        standby, no new grants
//   CPU_REQ    CPU access request (level)
//   CPU_ADDR   CPU erasable address
//   CNT_REQ    counter-increment request (level)
//   CNT_ADDR   counter address
//   CPU_GNT    one-clock CPU grant pulse (on the clock TP becomes 1)
//   CNT_GNT    one-clock CNT grant pulse (on the clock TP becomes 1)
//   TP         current time pulse, 1..12
//   BUSY       current MCT carries a granted access
//   XB_E       one-hot X-bottom enable, addr[2:0]
//   XT_E       one-hot X-top enable, addr[5:3]
//   YB_E       one-hot Y-bottom enable, addr[7:6]
//   REXY       read (reset) drive strobe, TP3
//   SBE        sense strobe, TP5..6
//   WEXY       rewrite drive strobe, TP9..10
//   CLRSA      sense-amp/buffer clear, TP12
// ---------------------------------------------------------------------------
module erasable_cycle_sequencer #(
   parameter int CNT_LIMIT = 4
) (
   input  logic       CLOCK,
   input  logic       rst_,
   input  logic       TICK,
   input  logic       GOJAM,
   input  logic       SBY,
   input  logic       CPU_REQ,
   input  logic [7:0] CPU_ADDR,
   input  logic       CNT_REQ,
   input  logic [7:0] CNT_ADDR,
   output logic       CPU_GNT,
   output logic       CNT_GNT,
   output logic [3:0] TP,
   output logic       BUSY,
   output logic [7:0] XB_E,
   output logic [7:0] XT_E,
   output logic [3:0] YB_E,
   output logic       REXY,
   output logic       SBE,
   output logic       WEXY,
   output logic       CLRSA
);

   // Who owns the current MCT; BUSY is simply "owner is not idle".
   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_CNT  = 2'd2
   } owner_t;

   localparam logic [3:0] LIMIT    = 4'(CNT_LIMIT);
   localparam logic [3:0] TP_FIRST = 4'd1;
   localparam logic [3:0] TP_LAST  = 4'd12;

   owner_t     owner_q, owner_d;
   logic [3:0] tp_q,     tp_d;
   logic [3:0] streak_q, streak_d;
   logic [7:0] addr_q,   addr_d;

   logic       cpu_gnt_d, cnt_gnt_d;
   logic       busy_d;
   logic       drive_win_d;
   logic [7:0] xb_d, xt_d;
   logic [3:0] yb_d;
   logic       rexy_d, sbe_d, wexy_d, clrsa_d;

   // Saturating streak increment: the counter parks at the limit so a long
   // CNT burst cannot wrap and starve the CPU.
   function automatic logic [3:0] streak_inc(input logic [3:0] v);
      if (v >= LIMIT) begin
         return LIMIT;
      end
      return v + 4'd1;
   endfunction

   function automatic logic [7:0] onehot8(input logic [2:0] sel);
      return 8'b0000_0001 << sel;
   endfunction

   function automatic logic [3:0] onehot4(input logic [1:0] sel);
      return 4'b0001 << sel;
   endfunction

   // TP12 is the arbitration point. Any out-of-range value (0, 13..15) is
   // also treated as end-of-MCT, so a corrupted counter recovers in one step.
   function automatic logic at_mct_end(input logic [3:0] t);
      return (t >= TP_LAST) || (t == 4'd0);
   endfunction

   // ---- next-state: time pulse, arbitration, address latch ----
   always_comb begin
      owner_d   = owner_q;
      tp_d      = tp_q;
      streak_d  = streak_q;
      addr_d    = addr_q;
      cpu_gnt_d = 1'b0;
      cnt_gnt_d = 1'b0;

      if (GOJAM) begin
         owner_d  = OWN_IDLE;
         tp_d     = TP_LAST;
         streak_d = 4'd0;
         addr_d   = 8'd0;
      end else if (TICK) begin
         if (at_mct_end(tp_q)) begin
            tp_d = TP_FIRST;
            if (SBY) begin
               owner_d  = OWN_IDLE;
               streak_d = 4'd0;
            end else if (CNT_REQ && !(CPU_REQ && (streak_q == LIMIT))) begin
               owner_d   = OWN_CNT;
               addr_d    = CNT_ADDR;
               streak_d  = streak_inc(streak_q);
               cnt_gnt_d = 1'b1;
            end else if (CPU_REQ) begin
               owner_d   = OWN_CPU;
               addr_d    = CPU_ADDR;
               streak_d  = 4'd0;
               cpu_gnt_d = 1'b1;
            end else begin
               owner_d  = OWN_IDLE;
               streak_d = 4'd0;
            end
         end else begin
            tp_d = tp_q + 4'd1;
         end
      end
   end

   // ---- output decode from next state ----
   // Enables and strobes are decoded from the next-state values. They are
   // then registered, so they change on the same edge as TP.
   // The enable window TP2..11 encloses every strobe (TP3, TP5..6, TP9..10),
   // so the enables are stable whenever a strobe is high.
   always_comb begin
      busy_d      = (owner_d != OWN_IDLE);
      drive_win_d = busy_d && (tp_d >= 4'd2) && (tp_d <= 4'd11);
      xb_d        = drive_win_d ? onehot8(addr_d[2:0]) : 8'd0;
      xt_d        = drive_win_d ? onehot8(addr_d[5:3]) : 8'd0;
      yb_d        = drive_win_d ? onehot4(addr_d[7:6]) : 4'd0;
      rexy_d      = busy_d && (tp_d == 4'd3);
      sbe_d       = busy_d && ((tp_d == 4'd5) || (tp_d == 4'd6));
      wexy_d      = busy_d && ((tp_d == 4'd9) || (tp_d == 4'd10));
      clrsa_d     = busy_d && (tp_d == TP_LAST);
   end

   // ---- state and output registers ----
   always_ff @(posedge CLOCK) begin
      if (!rst_) begin
         owner_q  <= OWN_IDLE;
         tp_q     <= TP_LAST;
         streak_q <= 4'd0;
         addr_q   <= 8'd0;
         CPU_GNT  <= 1'b0;
         CNT_GNT  <= 1'b0;
         TP       <= TP_LAST;
         BUSY     <= 1'b0;
         XB_E     <= 8'd0;
         XT_E     <= 8'd0;
         YB_E     <= 4'd0;
         REXY     <= 1'b0;
         SBE      <= 1'b0;
         WEXY     <= 1'b0;
         CLRSA    <= 1'b0;
      end else begin
         owner_q  <= owner_d;
         tp_q     <= tp_d;
         streak_q <= streak_d;
         addr_q   <= addr_d;
         CPU_GNT  <= cpu_gnt_d;
         CNT_GNT  <= cnt_gnt_d;
         TP       <= tp_d;
         BUSY     <= busy_d;
         XB_E     <= xb_d;
         XT_E     <= xt_d;
         YB_E     <= yb_d;
         REXY     <= rexy_d;
         SBE      <= sbe_d;
         WEXY     <= wexy_d;
         CLRSA    <= clrsa_d;
      end
   end

endmodule

// File: tb/tb_erasable_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_erasable_cycle_sequencer
//
// Purpose:
//   Self-checking bench for erasable_cycle_sequencer. Directed scenarios check
//   against hand-derived constants. A randomized run checks every clock
//   against a behavioural model of the MCT / arbitration rules.
// ---------------------------------------------------------------------------
module tb_erasable_cycle_sequencer;

   localparam int CNT_LIMIT = 4;

   logic       CLOCK    = 1'b0;
   logic       rst_     = 1'b0;
   logic       TICK     = 1'b0;
   logic       GOJAM    = 1'b0;
   logic       SBY      = 1'b0;
   logic       CPU_REQ  = 1'b0;
   logic [7:0] CPU_ADDR = 8'd0;
   logic       CNT_REQ  = 1'b0;
   logic [7:0] CNT_ADDR = 8'd0;
   logic       CPU_GNT, CNT_GNT, BUSY, REXY, SBE, WEXY, CLRSA;
   logic [3:0] TP, YB_E;
   logic [7:0] XB_E, XT_E;

   int errors = 0;
   int checks = 0;

   // Behavioural model state: time pulse as an integer, the MCT owner
   // (0 idle, 1 CPU, 2 CNT), the latched address and the CNT streak.
   int         m_tp     = 12;
   int         m_owner  = 0;
   int         m_streak = 0;
   logic [7:0] m_addr   = 8'd0;
   logic       m_cpu_g  = 1'b0;
   logic       m_cnt_g  = 1'b0;

   erasable_cycle_sequencer #(.CNT_LIMIT(CNT_LIMIT)) dut (
      .CLOCK   (CLOCK),
      .rst_    (rst_),
      .TICK    (TICK),
      .GOJAM   (GOJAM),
      .SBY     (SBY),
      .CPU_REQ (CPU_REQ),
      .CPU_ADDR(CPU_ADDR),
      .CNT_REQ (CNT_REQ),
      .CNT_ADDR(CNT_ADDR),
      .CPU_GNT (CPU_GNT),
      .CNT_GNT (CNT_GNT),
      .TP      (TP),
      .BUSY    (BUSY),
      .XB_E    (XB_E),
      .XT_E    (XT_E),
      .YB_E    (YB_E),
      .REXY    (REXY),
      .SBE     (SBE),
      .WEXY    (WEXY),
      .CLRSA   (CLRSA)
   );

   always #5 CLOCK = ~CLOCK;

   function automatic logic [30:0] dut_vec();
      return {CPU_GNT, CNT_GNT, TP, BUSY, XB_E, XT_E, YB_E, REXY, SBE, WEXY, CLRSA};
   endfunction

   function automatic logic [30:0] model_vec();
      logic       busy;
      logic [7:0] xb;
      logic [7:0] xt;
      logic [3:0] yb;
      busy = (m_owner != 0);
      xb   = 8'd0;
      xt   = 8'd0;
      yb   = 4'd0;
      if (busy && m_tp >= 2 && m_tp <= 11) begin
         xb = 8'd1 << (m_addr % 8);
         xt = 8'd1 << ((m_addr / 8) % 8);
         yb = 4'd1 << (m_addr / 64);
      end
      return {m_cpu_g, m_cnt_g, 4'(m_tp), busy, xb, xt, yb,
              busy && (m_tp == 3), busy && (m_tp == 5 || m_tp == 6),
              busy && (m_tp == 9 || m_tp == 10), busy && (m_tp == 12)};
   endfunction

   // Apply the MCT rules to the model for one clock edge.
   task automatic model_edge();
      m_cpu_g = 1'b0;
      m_cnt_g = 1'b0;
      if (!rst_ || GOJAM) begin
         m_tp     = 12;
         m_owner  = 0;
         m_addr   = 8'd0;
         m_streak = 0;
      end else if (TICK) begin
         if (m_tp == 12) begin
            m_tp = 1;
            if (SBY) begin
               m_owner  = 0;
               m_streak = 0;
            end else if (CNT_REQ && !(CPU_REQ && m_streak == CNT_LIMIT)) begin
               m_owner  = 2;
               m_addr   = CNT_ADDR;
               m_streak = (m_streak + 1 > CNT_LIMIT) ? CNT_LIMIT : m_streak + 1;
               m_cnt_g  = 1'b1;
            end else if (CPU_REQ) begin
               m_owner  = 1;
               m_addr   = CPU_ADDR;
               m_streak = 0;
               m_cpu_g  = 1'b1;
            end else begin
               m_owner  = 0;
               m_streak = 0;
            end
         end else begin
            m_tp = m_tp + 1;
         end
      end
   endtask

   // One clock: wait for the edge, advance the model, sample 1 time unit later.
   task automatic cyc();
      @(posedge CLOCK);
      model_edge();
      #1;
   endtask

   task automatic run_to_tp12();
      int n;
      n    = 0;
      TICK = 1'b1;
      while (m_tp != 12 && n < 20) begin
         cyc();
         n++;
      end
      TICK = 1'b0;
      checks++;
      if (TP !== 4'd12) begin
         errors++;
         $display("FAIL run_to_tp12: TP=%0d required 12 after %0d ticks", TP, n);
      end
   endtask

   task automatic test_reset();
      rst_    = 1'b0;
      TICK    = 1'b1;
      CPU_REQ = 1'b1;
      CNT_REQ = 1'b1;
      cyc();
      cyc();
      checks++;
      if (TP !== 4'd12 || {CPU_GNT, CNT_GNT, BUSY, XB_E, XT_E, YB_E, REXY, SBE, WEXY, CLRSA} !== 27'd0) begin
         errors++;
         $display("FAIL reset: got %h required TP=12, all else 0", dut_vec());
      end
      CPU_REQ = 1'b0;
      CNT_REQ = 1'b0;
      TICK    = 1'b0;
      rst_    = 1'b1;
   endtask

   task automatic test_idle_cycle();
      logic [30:0] exp;
      TICK = 1'b1;
      for (int i = 0; i < 13; i++) begin
         cyc();
         exp = {2'b00, 4'((i % 12) + 1), 25'd0};
         checks++;
         if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL idle_tick[%0d]: got %h required %h", i, dut_vec(), exp);
         end
      end
      TICK = 1'b0;
      cyc();
      checks++;
      if (TP !== 4'd1) begin
         errors++;
         $display("FAIL idle_hold: TP=%0d required 1", TP);
      end
      run_to_tp12();
   endtask

   task automatic test_cpu_access();
      logic [30:0] exp;
      CPU_REQ  = 1'b1;
      CPU_ADDR = 8'hA5;
      TICK     = 1'b1;
      cyc();
      checks++;
      if ({CPU_GNT, CNT_GNT, TP, BUSY} !== {1'b1, 1'b0, 4'd1, 1'b1}) begin
         errors++;
         $display("FAIL cpu_grant: got gnt=%b/%b TP=%0d BUSY=%b required 1/0 1 1", CPU_GNT, CNT_GNT, TP, BUSY);
      end
      CPU_REQ = 1'b0;
      for (int t = 2; t <= 12; t++) begin
         if (t == 6) CPU_ADDR = 8'h3C;
         cyc();
         exp = {2'b00, 4'(t), 1'b1,
                (t <= 11) ? 8'h20 : 8'h00, (t <= 11) ? 8'h10 : 8'h00, (t <= 11) ? 4'h4 : 4'h0,
                (t == 3), (t == 5 || t == 6), (t == 9 || t == 10), (t == 12)};
         checks++;
         if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL cpu_tp%0d: got %h required %h", t, dut_vec(), exp);
         end
         if (t == 5) begin
            TICK = 1'b0;
            cyc();
            checks++;
            if (dut_vec() !== exp) begin
               errors++;
               $display("FAIL cpu_hold_tp5: got %h required %h", dut_vec(), exp);
            end
            TICK = 1'b1;
         end
      end
      cyc();
      checks++;
      if ({CPU_GNT, CNT_GNT, BUSY, TP, XB_E} !== {3'b000, 4'd1, 8'h00}) begin
         errors++;
         $display("FAIL cpu_next_idle: got gnt=%b/%b BUSY=%b TP=%0d XB=%h required idle TP1", CPU_GNT, CNT_GNT, BUSY, TP, XB_E);
      end
      run_to_tp12();
   endtask

   task automatic test_arbitration();
      logic [5:0] exp_cnt;
      exp_cnt  = 6'b10_1111;
      CPU_REQ  = 1'b1;
      CNT_REQ  = 1'b1;
      CPU_ADDR = 8'h11;
      CNT_ADDR = 8'hC2;
      TICK     = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         checks++;
         if ({CNT_GNT, CPU_GNT} !== {exp_cnt[k], ~exp_cnt[k]}) begin
            errors++;
            $display("FAIL arb_mct%0d: got cnt/cpu=%b/%b required %b/%b", k, CNT_GNT, CPU_GNT, exp_cnt[k], ~exp_cnt[k]);
         end
         for (int t = 2; t <= 12; t++) begin
            cyc();
            checks++;
            if (dut_vec() !== model_vec()) begin
               errors++;
               $display("FAIL arb_mct%0d_tp%0d: got %h required %h", k, t, dut_vec(), model_vec());
            end
         end
      end
      TICK = 1'b0;
   endtask

   task automatic test_cnt_only();
      int n_cnt;
      int n_cpu;
      n_cnt   = 0;
      n_cpu   = 0;
      CPU_REQ = 1'b0;
      CNT_REQ = 1'b1;
      TICK    = 1'b1;
      for (int k = 0; k < 7; k++) begin
         CNT_ADDR = 8'($urandom);
         for (int t = 1; t <= 12; t++) begin
            cyc();
            n_cnt += int'(CNT_GNT);
            n_cpu += int'(CPU_GNT);
            if (t == 2) begin
               checks++;
               if (dut_vec() !== model_vec()) begin
                  errors++;
                  $display("FAIL cnt_only_mct%0d: got %h required %h", k, dut_vec(), model_vec());
               end
            end
         end
      end
      checks++;
      if (n_cnt != 7 || n_cpu != 0) begin
         errors++;
         $display("FAIL cnt_only_count: got cnt=%0d cpu=%0d required 7/0", n_cnt, n_cpu);
      end
      // Streak is saturated: a newly pending CPU request wins immediately.
      CPU_REQ = 1'b1;
      cyc();
      checks++;
      if ({CPU_GNT, CNT_GNT} !== 2'b10) begin
         errors++;
         $display("FAIL cnt_saturate: got cpu/cnt=%b/%b required 1/0", CPU_GNT, CNT_GNT);
      end
      CPU_REQ = 1'b0;
      CNT_REQ = 1'b0;
      run_to_tp12();
   endtask

   task automatic test_gojam();
      CPU_REQ  = 1'b1;
      CPU_ADDR = 8'h5A;
      TICK     = 1'b1;
      cyc();
      CPU_REQ = 1'b0;
      for (int t = 2; t <= 5; t++) cyc();
      checks++;
      if ({TP, SBE, XB_E, XT_E, YB_E} !== {4'd5, 1'b1, 8'h04, 8'h08, 4'h2}) begin
         errors++;
         $display("FAIL gojam_pre: got TP=%0d SBE=%b XB=%h XT=%h YB=%h required 5 1 04 08 2", TP, SBE, XB_E, XT_E, YB_E);
      end
      GOJAM   = 1'b1;
      CPU_REQ = 1'b1;
      cyc();
      checks++;
      if (dut_vec() !== {2'b00, 4'd12, 25'd0}) begin
         errors++;
         $display("FAIL gojam_abort: got %h required TP=12 all else 0", dut_vec());
      end
      GOJAM   = 1'b0;
      CPU_REQ = 1'b0;
      cyc();
      checks++;
      if ({CPU_GNT, BUSY, TP} !== {2'b00, 4'd1}) begin
         errors++;
         $display("FAIL gojam_forgot: got gnt=%b BUSY=%b TP=%0d required 0 0 1", CPU_GNT, BUSY, TP);
      end
      run_to_tp12();
      CPU_REQ = 1'b1;
      TICK    = 1'b1;
      cyc();
      CPU_REQ = 1'b0;
      cyc();
      checks++;
      if ({BUSY, TP, XB_E, XT_E, YB_E} !== {1'b1, 4'd2, 8'h04, 8'h08, 4'h2}) begin
         errors++;
         $display("FAIL gojam_rearb: got BUSY=%b TP=%0d XB=%h XT=%h YB=%h required 1 2 04 08 2", BUSY, TP, XB_E, XT_E, YB_E);
      end
      run_to_tp12();
   endtask

   task automatic test_standby();
      CPU_REQ  = 1'b1;
      CPU_ADDR = 8'h77;
      TICK     = 1'b1;
      cyc();
      checks++;
      if (CPU_GNT !== 1'b1) begin
         errors++;
         $display("FAIL sby_grant: got CPU_GNT=%b required 1", CPU_GNT);
      end
      CPU_REQ = 1'b0;
      for (int t = 2; t <= 12; t++) begin
         cyc();
         if (t == 7) SBY = 1'b1;
         if (t == 9 || t == 10 || t == 12) begin
            checks++;
            if ({WEXY, CLRSA} !== {(t != 12), (t == 12)}) begin
               errors++;
               $display("FAIL sby_tp%0d: got WEXY=%b CLRSA=%b required %b %b", t, WEXY, CLRSA, (t != 12), (t == 12));
            end
         end
      end
      CPU_REQ = 1'b1;
      cyc();
      checks++;
      if ({CPU_GNT, BUSY, TP} !== {2'b00, 4'd1}) begin
         errors++;
         $display("FAIL sby_idle: got gnt=%b BUSY=%b TP=%0d required 0 0 1", CPU_GNT, BUSY, TP);
      end
      run_to_tp12();
      SBY  = 1'b0;
      TICK = 1'b1;
      cyc();
      checks++;
      if ({CPU_GNT, BUSY} !== 2'b11) begin
         errors++;
         $display("FAIL sby_resume: got gnt=%b BUSY=%b required 1 1", CPU_GNT, BUSY);
      end
      CPU_REQ = 1'b0;
      run_to_tp12();
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         TICK  = ($urandom_range(0, 2) != 0);
         GOJAM = ($urandom_range(0, 99) == 0);
         rst_  = ($urandom_range(0, 149) != 0);
         if ($urandom_range(0, 79) == 0) SBY = ~SBY;
         if (!CPU_REQ && $urandom_range(0, 5) == 0) begin
            CPU_REQ  = 1'b1;
            CPU_ADDR = 8'($urandom);
         end
         if (!CNT_REQ && $urandom_range(0, 3) == 0) begin
            CNT_REQ  = 1'b1;
            CNT_ADDR = 8'($urandom);
         end
         cyc();
         if (m_cpu_g) CPU_REQ = 1'b0;
         if (m_cnt_g) CNT_REQ = 1'b0;
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL random[%0d]: got %h required %h", i, dut_vec(), model_vec());
         end
         checks++;
         if (REXY && WEXY) begin
            errors++;
            $display("FAIL random_rexy_wexy[%0d]: got both 1 required not both", i);
         end
      end
      TICK    = 1'b0;
      GOJAM   = 1'b0;
      rst_    = 1'b1;
      SBY     = 1'b0;
      CPU_REQ = 1'b0;
      CNT_REQ = 1'b0;
      cyc();
   endtask

   initial begin
      test_reset();
      test_idle_cycle();
      test_cpu_access();
      test_arbitration();
      test_cnt_only();
      test_gojam();
      test_standby();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
